// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the word-addressed data memory, with LOCK support.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise M0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_HI  = 31,
  parameter int MAX_LOCK = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              M0_REQ,
  input  logic              M1_REQ,
  input  logic [ADDR_HI:2]  M0_ADDR,
  input  logic [ADDR_HI:2]  M1_ADDR,
  input  logic [31:0]       M0_WDATA,
  input  logic [31:0]       M1_WDATA,
  input  logic [3:0]        M0_WSTB,
  input  logic [3:0]        M1_WSTB,
  input  logic              M0_LOCK,
  input  logic              M1_LOCK,
  output logic              M0_GNT,
  output logic              M1_GNT,
  output logic              M0_ACK,
  output logic              M1_ACK,
  output logic [31:0]       M0_RDATA,
  output logic [31:0]       M1_RDATA,
  output logic [ADDR_HI:2]  MEM_ADDR,
  output logic [31:0]       MEM_DATAI,
  input  logic [31:0]       MEM_DATAO,
  output logic              MEM_CE,
  output logic [3:0]        MEM_WSTB
);

  localparam logic [8:0] LOCK_LIMIT = 9'(MAX_LOCK);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              grant, sel, sel_lock, tie_pick;
  logic [ADDR_HI:2]  addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstb_q, wstb_d;
  logic              win_q, win_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              lock_act_q, lock_act_d, lock_own_q, lock_own_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic [8:0]        lock_inc;
  logic              rel_q, rel_d, rel_id_q, rel_id_d;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer names the requester that wins the next unlocked tie.
  assign ptr_d    = grant ? ~sel : ptr_q;
  assign tie_pick = ptr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  assign tie_pick = 1'b0;
`endif

  // Winner selection; gated by RST_N so no grant leaks out while in reset.
  always_comb begin
    grant = 1'b0;
    sel   = 1'b0;
    if (state_q == S_IDLE && RST_N) begin
      if (lock_act_q) begin
        sel   = lock_own_q;
        grant = lock_own_q ? M1_REQ : M0_REQ;
      end else if (M0_REQ && M1_REQ) begin
        grant = 1'b1;
        sel   = rel_q ? rel_id_q : tie_pick;
      end else begin
        grant = M0_REQ | M1_REQ;
        sel   = ~M0_REQ;
      end
    end
  end

  assign sel_lock = sel ? M1_LOCK : M0_LOCK;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant) state_d = S_ACCESS;
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    M0_GNT   = grant & ~sel;
    M1_GNT   = grant & sel;
    MEM_CE   = (state_q == S_ACCESS);
    MEM_WSTB = (state_q == S_ACCESS) ? wstb_q : 4'b0000;
  end

  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstb_d     = wstb_q;
    win_d      = win_q;
    lock_act_d = lock_act_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    rel_d      = rel_q;
    rel_id_d   = rel_id_q;
    lock_inc   = {1'b0, lock_cnt_q} + 9'd1;
    if (grant) begin
      addr_d  = sel ? M1_ADDR  : M0_ADDR;
      wdata_d = sel ? M1_WDATA : M0_WDATA;
      wstb_d  = sel ? M1_WSTB  : M0_WSTB;
      win_d   = sel;
      rel_d   = 1'b0;
      if (!sel_lock) begin
        lock_act_d = 1'b0;
        lock_cnt_d = 8'd0;
      end else if (lock_inc >= LOCK_LIMIT) begin
        // Forced release hands the next tie to the requester that was kept waiting.
        lock_act_d = 1'b0;
        lock_cnt_d = 8'd0;
        rel_d      = 1'b1;
        rel_id_d   = ~sel;
      end else begin
        lock_act_d = 1'b1;
        lock_own_d = sel;
        lock_cnt_d = lock_inc[7:0];
      end
    end
    ack0_d   = (state_q == S_ACCESS) && !win_q;
    ack1_d   = (state_q == S_ACCESS) && win_q;
    rdata0_d = ack0_d ? MEM_DATAO : rdata0_q;
    rdata1_d = ack1_d ? MEM_DATAO : rdata1_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wstb_q     <= '0;
      win_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      lock_act_q <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= '0;
      rel_q      <= 1'b0;
      rel_id_q   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstb_q     <= wstb_d;
      win_q      <= win_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
      rel_q      <= rel_d;
      rel_id_q   <= rel_id_d;
    end
  end

  assign M0_ACK    = ack0_q;
  assign M1_ACK    = ack1_q;
  assign M0_RDATA  = rdata0_q;
  assign M1_RDATA  = rdata1_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_DATAI = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level model predicts grants and ACK data.
module tb_dmem_arbiter;
  localparam int MAXL = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N;
  logic M0_REQ, M1_REQ, M0_LOCK, M1_LOCK;
  logic [31:2] M0_ADDR, M1_ADDR, MEM_ADDR;
  logic [31:0] M0_WDATA, M1_WDATA, M0_RDATA, M1_RDATA, MEM_DATAI, MEM_DATAO;
  logic [3:0] M0_WSTB, M1_WSTB, MEM_WSTB;
  logic M0_GNT, M1_GNT, M0_ACK, M1_ACK, MEM_CE;

  dmem_arbiter #(.ADDR_HI(31), .MAX_LOCK(MAXL)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .M0_REQ(M0_REQ), .M1_REQ(M1_REQ), .M0_ADDR(M0_ADDR), .M1_ADDR(M1_ADDR),
    .M0_WDATA(M0_WDATA), .M1_WDATA(M1_WDATA), .M0_WSTB(M0_WSTB), .M1_WSTB(M1_WSTB),
    .M0_LOCK(M0_LOCK), .M1_LOCK(M1_LOCK), .M0_GNT(M0_GNT), .M1_GNT(M1_GNT),
    .M0_ACK(M0_ACK), .M1_ACK(M1_ACK), .M0_RDATA(M0_RDATA), .M1_RDATA(M1_RDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_DATAI(MEM_DATAI), .MEM_DATAO(MEM_DATAO),
    .MEM_CE(MEM_CE), .MEM_WSTB(MEM_WSTB)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [64];
  assign MEM_DATAO = mem[MEM_ADDR[7:2]];

  typedef struct { logic [5:0] a; logic [31:0] wd; logic [3:0] st; logic lk; int gap; } req_t;
  typedef struct { int id; logic [31:0] rd; int due; } exp_t;

  req_t        pq [2][$];
  req_t        cur [2];
  bit          act [2];
  bit          gnt_last [2];
  exp_t        exp_q [$];
  int          gl [$];
  logic [31:0] ref_mem [64];
  logic [31:0] last_rd [2];
  req_t        acc_r;
  int          own, cnt, force_id, ptr, cyc, undo_idx;
  bit          busy;
  logic [31:0] undo_val;
  int          n_tests, n_fail;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic drive();
    M0_REQ = act[0]; M0_ADDR = {24'b0, cur[0].a}; M0_WDATA = cur[0].wd;
    M0_WSTB = cur[0].st; M0_LOCK = cur[0].lk;
    M1_REQ = act[1]; M1_ADDR = {24'b0, cur[1].a}; M1_WDATA = cur[1].wd;
    M1_WSTB = cur[1].st; M1_LOCK = cur[1].lk;
  endtask

  task automatic push(input int m, input logic [5:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic lk, input int gap);
    req_t r;
    r.a = a; r.wd = wd; r.st = st; r.lk = lk; r.gap = gap;
    pq[m].push_back(r);
  endtask

  task automatic model_reset();
    own = -1; cnt = 0; force_id = -1; ptr = 0; busy = 0;
    gnt_last[0] = 0; gnt_last[1] = 0; act[0] = 0; act[1] = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    exp_q.delete();
  endtask

  // Accepted request: expected read word is the pre-write contents; then apply the write.
  task automatic grant(input int e);
    req_t r;
    exp_t x;
    r = cur[e];
    acc_r = r;
    gl.push_back(e);
    x.id = e; x.rd = ref_mem[r.a]; x.due = cyc + 2;
    exp_q.push_back(x);
    undo_idx = int'(r.a); undo_val = ref_mem[r.a];
    for (int b = 0; b < 4; b++)
      if (r.st[b]) ref_mem[r.a][8*b +: 8] = r.wd[8*b +: 8];
    force_id = -1;
    ptr = 1 - e;
    if (r.lk) begin
      cnt++;
      if (cnt >= MAXL) begin own = -1; cnt = 0; force_id = 1 - e; end
      else own = e;
    end else begin
      own = -1; cnt = 0;
    end
  endtask

  task automatic model_cycle();
    int e;
    logic [1:0] want;
    if (busy) begin
      chk("mem_ce_access", 64'(MEM_CE), 64'(1));
      chk("mem_addr", 64'(MEM_ADDR), 64'(acc_r.a));
      chk("mem_wstb", 64'(MEM_WSTB), 64'(acc_r.st));
      chk("mem_datai", 64'(MEM_DATAI), 64'(acc_r.wd));
    end else begin
      chk("mem_ce_idle", 64'({MEM_CE, MEM_WSTB}), 64'(0));
    end
    e = -1;
    if (!busy) begin
      if (own >= 0) begin
        if (act[own]) e = own;
      end else if (act[0] && act[1]) begin
        if (force_id >= 0) e = force_id;
        else e = RR ? ptr : 0;
      end else if (act[0]) e = 0;
      else if (act[1]) e = 1;
    end
    want = (e == 0) ? 2'b01 : (e == 1) ? 2'b10 : 2'b00;
    chk("gnt", 64'({M1_GNT, M0_GNT}), 64'(want));
    busy = (e >= 0);
    gnt_last[0] = (e == 0);
    gnt_last[1] = (e == 1);
    if (e >= 0) grant(e);
  endtask

  task automatic step();
    req_t t;
    @(posedge CLK); #1;
    for (int m = 0; m < 2; m++) begin
      if (gnt_last[m]) act[m] = 0;
      if (!act[m] && pq[m].size() > 0) begin
        t = pq[m][0];
        if (t.gap > 0) begin t.gap--; pq[m][0] = t; end
        else begin cur[m] = pq[m].pop_front(); act[m] = 1; end
      end
    end
    drive();
    @(negedge CLK);
    model_cycle();
  endtask

  task automatic run(input int budget, input string nm);
    int n = 0;
    while ((pq[0].size() > 0 || pq[1].size() > 0 || act[0] || act[1] || busy ||
            exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_drained"}, 64'(n < budget), 64'(1));
    if (n >= budget) begin
      pq[0].delete(); pq[1].delete(); exp_q.delete();
    end
  endtask

  function automatic logic [7:0] order_bits();
    logic [7:0] o = '0;
    for (int i = 0; i < gl.size() && i < 8; i++) o[i] = (gl[i] == 1);
    return o;
  endfunction

  task automatic mem_proc();
    logic ce;
    logic [5:0] ix;
    logic [31:0] d;
    logic [3:0] s;
    forever begin
      @(negedge CLK);
      ce = MEM_CE; ix = MEM_ADDR[7:2]; d = MEM_DATAI; s = MEM_WSTB;
      @(posedge CLK); #1;
      if (ce)
        for (int b = 0; b < 4; b++)
          if (s[b]) mem[ix][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (M0_ACK || M1_ACK) begin
          chk("ack_onehot", 64'(M0_ACK & M1_ACK), 64'(0));
          if (exp_q.size() == 0) begin
            chk("ack_unexpected", 64'(1), 64'(0));
          end else begin
            x = exp_q.pop_front();
            chk("ack_id", 64'(M1_ACK), 64'(x.id));
            chk("ack_cycle", 64'(cyc), 64'(x.due));
            chk("ack_rdata", 64'(x.id == 1 ? M1_RDATA : M0_RDATA), 64'(x.rd));
            last_rd[x.id] = x.rd;
          end
        end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          x = exp_q.pop_front();
          chk("ack_missing", 64'(0), 64'(1));
        end
        chk("rdata0_hold", 64'(M0_RDATA), 64'(last_rd[0]));
        chk("rdata1_hold", 64'(M1_RDATA), 64'(last_rd[1]));
      end
    end
  endtask

  task automatic cyc_proc();
    forever begin @(posedge CLK); cyc++; end
  endtask

  initial begin
    logic [31:0] v;
    int k, bad;
    n_tests = 0; n_fail = 0; cyc = 0;
    RST_N = 1'b0;
    for (int m = 0; m < 2; m++) begin
      cur[m].a = '0; cur[m].wd = '0; cur[m].st = '0; cur[m].lk = 1'b0; cur[m].gap = 0;
    end
    model_reset();
    drive();
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    fork
      mem_proc();
      monitor();
      cyc_proc();
    join_none

    // Reset: outputs zero even with both requests raised.
    M0_REQ = 1'b1; M1_REQ = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_ctrl", 64'({M0_GNT, M1_GNT, M0_ACK, M1_ACK, MEM_CE, MEM_WSTB}), 64'(0));
    chk("rst_rdata", {M0_RDATA, M1_RDATA}, 64'(0));
    chk("rst_mem", 64'({MEM_ADDR, MEM_DATAI}), 64'(0));
    drive();
    @(posedge CLK); #1 RST_N = 1'b1;

    // Single M0 read of word 0x10.
    v = ref_mem[16];
    push(0, 6'h10, $urandom, 4'b0000, 1'b0, 0);
    run(20, "p1");
    chk("p1_rdata", 64'(M0_RDATA), 64'(v));

    // M1 partial write over a known word.
    mem[32] = 32'h11223344; ref_mem[32] = 32'h11223344;
    push(1, 6'h20, 32'hDEADBEEF, 4'b0011, 1'b0, 0);
    run(20, "p2");
    chk("p2_mem", 64'(mem[32]), 64'(32'h1122BEEF));
    chk("p2_rdata", 64'(M1_RDATA), 64'(32'h11223344));

    // Simultaneous requests, four rounds.
    gl.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 6'($urandom_range(0, 15)), $urandom, 4'($urandom), 1'b0, 0);
      push(1, 6'($urandom_range(0, 15)), $urandom, 4'b0000, 1'b0, 0);
    end
    run(60, "p3");
    chk("p3_count", 64'(gl.size()), 64'(8));
    chk("p3_order", 64'(order_bits() & 8'h0F), RR ? 64'(8'h0A) : 64'(8'h00));

    // M1 locked for three beats, unlocks on the fourth; M0 waits.
    gl.delete();
    push(1, 6'h01, $urandom, 4'b0000, 1'b1, 0);
    push(1, 6'h02, $urandom, 4'b1111, 1'b1, 0);
    push(1, 6'h03, $urandom, 4'b0000, 1'b1, 0);
    push(1, 6'h04, $urandom, 4'b0101, 1'b0, 0);
    push(0, 6'h05, $urandom, 4'b0000, 1'b0, 1);
    run(60, "p4");
    chk("p4_count", 64'(gl.size()), 64'(5));
    chk("p4_order", 64'(order_bits()), 64'(8'h0F));

    // M0 holds LOCK past the MAX_LOCK limit while M1 waits.
    gl.delete();
    for (int i = 0; i < 6; i++) push(0, 6'(8 + i), $urandom, 4'b0000, 1'b1, 0);
    push(0, 6'h0E, $urandom, 4'b0000, 1'b0, 0);
    push(1, 6'h0F, $urandom, 4'b1000, 1'b0, 1);
    run(80, "p5");
    chk("p5_count", 64'(gl.size()), 64'(8));
    chk("p5_order", 64'(order_bits()), 64'(8'h10));

    // Reset asserted while a write to 0x30 is in its access cycle.
    v = $urandom;
    mem[48] = v; ref_mem[48] = v;
    gl.delete();
    push(0, 6'h30, ~v, 4'b1111, 1'b0, 0);
    k = 0;
    while (gl.size() == 0 && k < 10) begin step(); k++; end
    chk("p6_granted", 64'(gl.size()), 64'(1));
    @(posedge CLK); #1;
    RST_N = 1'b0;
    model_reset();
    ref_mem[undo_idx] = undo_val;
    drive();
    #1;
    chk("p6_rst_ctrl", 64'({M0_GNT, M1_GNT, M0_ACK, M1_ACK, MEM_CE, MEM_WSTB}), 64'(0));
    chk("p6_rst_mem", 64'({MEM_ADDR, MEM_DATAI}), 64'(0));
    @(posedge CLK);
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("p6_mem_kept", 64'(mem[48]), 64'(v));
    chk("p6_no_ack", 64'({M0_ACK, M1_ACK}), 64'(0));
    push(1, 6'h30, $urandom, 4'b0000, 1'b0, 0);
    run(20, "p6");

    // Randomised traffic with locks, gaps and writes.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 40; i++)
        push(m, 6'($urandom_range(0, 15)), $urandom,
             ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000,
             (i < 39) && ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    run(2000, "p7");

    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", 64'(bad), 64'(0));
    chk("exp_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the word-addressed data memory.
- Shares the memory between M0 (CPU load/store unit) and M1 (DMA/debug port).
- Latches the winning request, drives the memory for exactly one access cycle, then returns registered read data and an ACK.
- Supports a LOCK for atomic multi-beat sequences, with a bounded lock length.

Parameters:
- ADDR_HI, 31: MSB of the word address; word address is ADDR[ADDR_HI:2].
- MAX_LOCK, 8: maximum consecutive grants to one requester under LOCK before a forced release. Legal range 1..255.

Ports:
- CLK  in  1  system clock; rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- M0_REQ, M1_REQ  in  1 each  request; held with its fields until GNT is seen.
- M0_ADDR, M1_ADDR  in  [ADDR_HI:2]  word address.
- M0_WDATA, M1_WDATA  in  32  write data.
- M0_WSTB, M1_WSTB  in  4  byte write strobes; 4'b0000 means read.
- M0_LOCK, M1_LOCK  in  1  keep the grant for the next request.
- M0_GNT, M1_GNT  out  1  combinational grant pulse; request captured on this edge.
- M0_ACK, M1_ACK  out  1  registered one-cycle completion pulse.
- M0_RDATA, M1_RDATA  out  32  registered read data; valid with ACK.
- MEM_ADDR  out  [ADDR_HI:2]  to memory ADDR.
- MEM_DATAI  out  32  to memory DATAI.
- MEM_DATAO  in  32  from memory DATAO (combinational read).
- MEM_CE  out  1  to memory CE.
- MEM_WSTB  out  4  to memory WSTB.

Behaviour:
- States: IDLE, ACCESS. Reset enters IDLE asynchronously.
- Reset values:
  - GNT/ACK = 0; RDATA = 0; MEM_CE = 0; MEM_WSTB = 0; MEM_ADDR/MEM_DATAI = 0.
  - Lock owner none; lock counter 0; round-robin pointer = M0.
- IDLE:
  - If any REQ, pick a winner and assert its GNT combinationally that cycle.
  - On the edge: latch the winner's ADDR/WDATA/WSTB/LOCK and the winner id; go to ACCESS.
  - No REQ: stay in IDLE; GNT = 0.
- ACCESS (exactly 1 cycle):
  - MEM_CE = 1; MEM_ADDR/MEM_DATAI/MEM_WSTB from latched values. Outside ACCESS, MEM_CE = 0 and MEM_WSTB = 0.
  - On the edge: winner ACK <= 1 for one cycle; winner RDATA <= MEM_DATAO (pre-write word, for both read and write); return to IDLE.
  - The memory commits the write on the same edge.
- Timing:
  - REQ high in cycle N (IDLE) → GNT in N → ACCESS in N+1 → ACK/RDATA in N+2.
  - Peak throughput is 1 access per 2 cycles.
  - The ACK cycle is an IDLE cycle, so a new grant may coincide with ACK.
- Requester rule: deassert REQ, or present the next request, in the cycle after GNT. A REQ still high after GNT is treated as a new request.
- Winner selection (no lock active): per macro, see Optional Feature. If only one REQ is high, that requester wins.
- Lock:
  - A latched LOCK = 1 makes that requester lock owner.
  - While a lock is held, IDLE grants only the owner; the other requester waits even if the owner is idle.
  - Lock releases when a granted owner request has LOCK = 0, or when the lock counter reaches MAX_LOCK.
  - At the MAX_LOCK release, the other requester wins the next arbitration if requesting.
  - The lock counter counts granted beats under lock and clears on release.
- RDATA holds its last value between ACKs.
- Reset asserted mid-ACCESS: MEM_CE drops immediately, so no write occurs on any edge while RST_N = 0; no ACK is issued; the lock is cleared.
- Address is passed through unmodified; no range check.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin between unlocked requesters. On simultaneous REQ, the requester not granted last wins. The pointer updates on every grant.
- Undefined: fixed priority, M0 always wins simultaneous REQ. M1 can starve; accepted. No pointer register is built.

Test Plan:
- Reset then M0 read ADDR=0x10 → M0_GNT in cycle 0; MEM_CE=1, MEM_WSTB=0 in cycle 1; M0_ACK=1 in cycle 2 with M0_RDATA=mem[0x10]; RST_N low mid-test → all outputs 0.
- M1 write ADDR=0x20, WDATA=0xDEADBEEF, WSTB=4'b0011 over word 0x11223344 → after ACK, mem[0x20]=0x1122BEEF; M1_RDATA=0x11223344.
- M0 and M1 request together, 4 rounds → without macro M0 wins all rounds; with DMEM_ARB_RR_EN grants alternate M0, M1, M0, M1.
- M1 LOCK=1 for 3 beats then LOCK=0 while M0_REQ is held high → M0_GNT=0 until after M1's 4th grant; M0 granted next.
- MAX_LOCK=2; M0 holds LOCK=1 continuously with M1_REQ high → M0 granted twice, then M1 granted.
- RST_N asserted during an ACCESS write to 0x30 → mem[0x30] unchanged; no ACK; state IDLE on release.
